// File: rtl/gpr_mport_sb_pkg.sv
// Shared constants for the multi-port GPR file and its scoreboard.
// Holds the default register geometry and the zero-register address.
// The optional forwarding path is selected by the GPR_BYPASS_EN macro.
package gpr_mport_sb_pkg;

  localparam int unsigned GPR_DATA_W = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_NUM_RD = 2;
  localparam int unsigned GPR_NUM_WR = 1;
  localparam logic [GPR_ADDR_W-1:0] GPR_ZERO_ADDR = 5'd0;

endpackage

// File: rtl/gpr_mport_sb_if.sv
// Bus bundle between decode/writeback (master) and the GPR file (slave).
// Carries the packed write ports, read ports, issue claim, flush and debug busy vector.
interface gpr_mport_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);

  logic [NUM_WR-1:0]        wr_en_i;
  logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
  logic [NUM_WR*DATA_W-1:0] wr_data_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0]        rd_busy_o;
  logic                     issue_en_i;
  logic [ADDR_W-1:0]        issue_addr_i;
  logic                     issue_ok_o;
  logic                     flush_i;
  logic [(2**ADDR_W)-1:0]   busy_vec_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, issue_en_i, issue_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, issue_ok_o, busy_vec_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, issue_en_i, issue_addr_i, flush_i,
    output rd_data_o, rd_busy_o, issue_ok_o, busy_vec_o
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Ports: clk, rst_n; wr_en/wr_addr clear bits; issue_en/issue_addr set a bit when
// issue_ok_c; flush clears everything; busy is the registered bit vector.
module gpr_scoreboard
  import gpr_mport_sb_pkg::*;
#(
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned NUM_WR  = GPR_NUM_WR,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic                     issue_ok_c,
  output logic [(2**ADDR_W)-1:0]   busy
);

  logic [(2**ADDR_W)-1:0] busy_nxt;

  assign issue_ok_c = ~busy[issue_addr];

  // Clears first so a same-address claim in the same cycle wins.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < int'(NUM_WR); k++) begin
      if (wr_en[k]) busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (flush) begin
      busy_nxt = '0;
    end else if (issue_en && issue_ok_c) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    if (ZERO_R0 != 0) busy_nxt[ADDR_W'(GPR_ZERO_ADDR)] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/gpr_mport_sb.sv
// Multi-port general-purpose register file with integrated write scoreboard.
// Ports: clk, rst_n (async active-low); bus (slave modport) carrying NUM_WR write
// ports, NUM_RD combinational read ports with busy flags, issue claim/ok, flush and
// the debug busy vector. Define GPR_BYPASS_EN for same-cycle write-to-read forwarding.
module gpr_mport_sb
  import gpr_mport_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = GPR_DATA_W,
  parameter int unsigned ADDR_W  = GPR_ADDR_W,
  parameter int unsigned NUM_RD  = GPR_NUM_RD,
  parameter int unsigned NUM_WR  = GPR_NUM_WR,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  gpr_mport_sb_if.slave bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(GPR_ZERO_ADDR);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  gpr_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_WR  (NUM_WR),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (bus.wr_en_i),
    .wr_addr    (bus.wr_addr_i),
    .issue_en   (bus.issue_en_i),
    .issue_addr (bus.issue_addr_i),
    .flush      (bus.flush_i),
    .issue_ok_c (bus.issue_ok_o),
    .busy       (busy)
  );

  // Storage; later ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(DEPTH); r++) mem[r] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (bus.wr_en_i[k] &&
            !((ZERO_R0 != 0) && (bus.wr_addr_i[k*ADDR_W +: ADDR_W] == ZERO_ADDR))) begin
          mem[bus.wr_addr_i[k*ADDR_W +: ADDR_W]] <= bus.wr_data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read muxes with optional forwarding of the in-flight write.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      ra = bus.rd_addr_i[i*ADDR_W +: ADDR_W];
      rd = mem[ra];
      rb = busy[ra];
      if ((ZERO_R0 != 0) && (ra == ZERO_ADDR)) begin
        rd = '0;
        rb = 1'b0;
      end
`ifdef GPR_BYPASS_EN
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (bus.wr_en_i[k] && (bus.wr_addr_i[k*ADDR_W +: ADDR_W] == ra) &&
            !((ZERO_R0 != 0) && (ra == ZERO_ADDR))) begin
          rd = bus.wr_data_i[k*DATA_W +: DATA_W];
          rb = 1'b0;
        end
      end
      // Forwarding must not leak write data while held in reset.
      if (!rst_n) rd = '0;
`endif
      rd_data_c[i*DATA_W +: DATA_W] = rd;
      rd_busy_c[i] = rb;
    end
  end

  assign bus.rd_data_o  = rd_data_c;
  assign bus.rd_busy_o  = rd_busy_c;
  assign bus.busy_vec_o = busy;

endmodule

// File: tb/tb_gpr_mport_sb.sv
// Directed self-checking bench for gpr_mport_sb (DATA_W=32, ADDR_W=5, NUM_RD=2, NUM_WR=2).
// Expected values are queued when stimulus is driven and popped when the result is sampled.
module tb_gpr_mport_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [31:0] exp_q[$];

  gpr_mport_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  gpr_mport_sb #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .NUM_WR (NW), .ZERO_R0 (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got);
    logic [31:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: got %h, no expected value queued", tag, got);
    end else begin
      e = exp_q.pop_front();
      assert (got === e) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, e);
    end
  endtask

  task automatic idle();
    bus.wr_en_i    = '0;
    bus.issue_en_i = 1'b0;
    bus.flush_i    = 1'b0;
  endtask

  task automatic drv_wr(input int k, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en_i[k]             = 1'b1;
    bus.wr_addr_i[k*AW +: AW]  = a;
    bus.wr_data_i[k*DW +: DW]  = d;
  endtask

  task automatic set_rd(input int i, input logic [4:0] a);
    bus.rd_addr_i[i*AW +: AW] = a;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_en_i   = 1'b1;
    bus.issue_addr_i = a;
  endtask

  function automatic logic [31:0] rdd(input int i);
    return bus.rd_data_o[i*DW +: DW];
  endfunction

  function automatic logic [31:0] rdb(input int i);
    return 32'(bus.rd_busy_o[i]);
  endfunction

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.wr_en_i = '0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.rd_addr_i = '0; bus.issue_en_i = 1'b0; bus.issue_addr_i = '0; bus.flush_i = 1'b0;

    // Reset state
    #3;
    exp_q.push_back(32'h0); chk("rst_rd0", rdd(0));
    exp_q.push_back(32'h0); chk("rst_rd1", rdd(1));
    exp_q.push_back(32'h0); chk("rst_busy", 32'(bus.rd_busy_o));
    exp_q.push_back(32'h0); chk("rst_vec", 32'(bus.busy_vec_o));
    exp_q.push_back(32'h1); chk("rst_ok", 32'(bus.issue_ok_o));
    @(negedge clk) rst_n = 1'b1;

    // Basic write then read, zero register
    @(negedge clk); idle(); drv_wr(0, 5'd5, 32'hDEADBEEF); set_rd(0, 5'd5);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk); idle(); #1 chk("r5", rdd(0));
    drv_wr(0, 5'd0, 32'h1234); set_rd(0, 5'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk); idle(); #1 chk("r0_data", rdd(0)); chk("r0_busy", rdb(0));
    issue(5'd0);
    exp_q.push_back(32'h1); #1 chk("r0_ok", 32'(bus.issue_ok_o));
    exp_q.push_back(32'h0);
    @(negedge clk); idle(); #1 chk("r0_vec", 32'(bus.busy_vec_o));

    // Two ports to the same register: port 1 wins
    drv_wr(0, 5'd7, 32'h11); drv_wr(1, 5'd7, 32'h22); set_rd(1, 5'd7);
    exp_q.push_back(32'h22);
    @(negedge clk); idle(); #1 chk("r7_prio", rdd(1));

    // Issue, retry while busy, writeback
    issue(5'd3);
    exp_q.push_back(32'h1); #1 chk("r3_ok_pre", 32'(bus.issue_ok_o));
    @(negedge clk); idle(); set_rd(0, 5'd3);
    exp_q.push_back(32'h8); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    #1 chk("r3_vec", 32'(bus.busy_vec_o)); chk("r3_ok", 32'(bus.issue_ok_o)); chk("r3_rdbusy", rdb(0));
    issue(5'd3);
    @(negedge clk); idle();
    exp_q.push_back(32'h8); #1 chk("r3_retry", 32'(bus.busy_vec_o));
    drv_wr(0, 5'd3, 32'h33);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h33);
    @(negedge clk); idle();
    #1 chk("r3_clr_vec", 32'(bus.busy_vec_o)); chk("r3_clr_ok", 32'(bus.issue_ok_o)); chk("r3_data", rdd(0));

    // Same-cycle writeback and claim on r4: claim wins
    drv_wr(0, 5'd4, 32'h44); issue(5'd4);
    exp_q.push_back(32'h10);
    @(negedge clk); idle(); #1 chk("r4_setwins", 32'(bus.busy_vec_o));
    issue(5'd1); @(negedge clk); idle();
    issue(5'd2); @(negedge clk); idle();
    issue(5'd9); @(negedge clk); idle();
    exp_q.push_back(32'h216); #1 chk("pre_flush", 32'(bus.busy_vec_o));
    // Flush drops claims and a same-cycle issue; the write still commits
    bus.flush_i = 1'b1; issue(5'd10); drv_wr(0, 5'd11, 32'h77);
    exp_q.push_back(32'h0); exp_q.push_back(32'h77);
    @(negedge clk); idle(); set_rd(1, 5'd11);
    #1 chk("flush_vec", 32'(bus.busy_vec_o)); chk("flush_wr", rdd(1));

    // Write r6 while reading it
    drv_wr(0, 5'd6, 32'h1111);
    @(negedge clk); idle(); issue(5'd6);
    @(negedge clk); idle(); drv_wr(0, 5'd6, 32'hA5A5A5A5); set_rd(0, 5'd6);
`ifdef GPR_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'h0);
`else
    exp_q.push_back(32'h1111); exp_q.push_back(32'h1);
`endif
    #1 chk("r6_same", rdd(0)); chk("r6_same_busy", rdb(0));
    exp_q.push_back(32'hA5A5A5A5); exp_q.push_back(32'h0);
    @(negedge clk); idle(); #1 chk("r6_next", rdd(0)); chk("r6_next_busy", rdb(0));

    // Asynchronous reset in the middle of traffic
    drv_wr(0, 5'd8, 32'h88);
    @(negedge clk); idle(); issue(5'd12);
    @(negedge clk); idle(); set_rd(0, 5'd8); set_rd(1, 5'd12);
    exp_q.push_back(32'h88); exp_q.push_back(32'h1);
    #1 chk("r8_pre", rdd(0)); chk("r12_busy_pre", rdb(1));
    drv_wr(0, 5'd8, 32'h99); drv_wr(1, 5'd13, 32'hCC); issue(5'd12);
    #1 rst_n = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    #1 chk("mid_rst_rd0", rdd(0)); chk("mid_rst_busy", 32'(bus.rd_busy_o));
    chk("mid_rst_vec", 32'(bus.busy_vec_o)); chk("mid_rst_ok", 32'(bus.issue_ok_o));
    @(negedge clk); idle();
    exp_q.push_back(32'h0); #1 chk("rst_hold_rd0", rdd(0));
    rst_n = 1'b1;
    set_rd(0, 5'd13);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk); #1 chk("post_rst_r13", rdd(0)); chk("post_rst_vec", 32'(bus.busy_vec_o));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
